// File: rtl/svc_rv_dmem_resp.sv
// Data-memory responder for the svc_rv core: BRAM-timed word storage with byte strobes
// and a fixed per-read stall. Define SVC_RV_DMEM_RESP_ASSERT_EN to enable protocol checks.
module svc_rv_dmem_resp #(
   parameter int    AW         = 10,
   parameter int    READ_STALL = 2,
   parameter string INIT_FILE  = ""
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        dmem_ren,
   input  logic [31:0] dmem_raddr,
   output logic [31:0] dmem_rdata,
   input  logic        dmem_we,
   input  logic [31:0] dmem_waddr,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_wstrb,
   output logic        dmem_stall
);

   typedef enum logic {
      IDLE,
      WAIT
   } state_t;

   localparam logic [2:0] CNT_INIT = (READ_STALL > 0) ? 3'(READ_STALL - 1) : 3'd0;

   state_t        state;
   logic [2:0]    cnt;
   logic [31:0]   mem [2**AW];
   logic [AW-1:0] ridx;
   logic [AW-1:0] widx;
   logic          unused_addr_bits;

   // Out-of-range indices alias by truncation; byte offsets are dropped.
   assign ridx = dmem_raddr[AW+1:2];
   assign widx = dmem_waddr[AW+1:2];
   assign unused_addr_bits = ^{dmem_raddr[31:AW+2], dmem_raddr[1:0],
                               dmem_waddr[31:AW+2], dmem_waddr[1:0]};

   // Stall must rise in the same cycle as the request so the core holds it.
   always_comb begin
      dmem_stall = 1'b0;
      if (state == IDLE) dmem_stall = dmem_ren && (READ_STALL > 0);
      else               dmem_stall = (cnt != 3'd0);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         cnt        <= 3'd0;
         dmem_rdata <= 32'h0;
      end else begin
         unique case (state)
            IDLE: begin
               if (dmem_ren) begin
                  if (READ_STALL == 0) begin
                     dmem_rdata <= mem[ridx];
                  end else begin
                     state <= WAIT;
                     cnt   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt != 3'd0) begin
                  cnt <= cnt - 3'd1;
               end else begin
                  dmem_rdata <= mem[ridx];
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: the storage array has no reset so it maps onto block RAM; only control and
   // the output register are reset. Non-blocking writes give read-first behaviour when
   // a capture and a write hit the same word on the same edge.
   always_ff @(posedge clk) begin
      if (dmem_we && !dmem_stall) begin
         for (int i = 0; i < 4; i++) begin
            if (dmem_wstrb[i]) mem[widx][8*i +: 8] <= dmem_wdata[8*i +: 8];
         end
      end
   end

`ifdef SVC_RV_DMEM_RESP_ASSERT_EN
   if (READ_STALL > 7) begin : g_bad_stall
      $error("svc_rv_dmem_resp: READ_STALL must be in 0..7");
   end

   a_read_hold: assert property (@(posedge clk) disable iff (!rst_n)
      dmem_stall |=> ($stable(dmem_ren) && $stable(dmem_raddr)));

   a_write_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (dmem_stall && dmem_we) |=> ($stable(dmem_we) && $stable(dmem_waddr) &&
                                   $stable(dmem_wdata) && $stable(dmem_wstrb)));

   a_cnt_range: assert property (@(posedge clk) disable iff (!rst_n)
      (READ_STALL == 0) || (int'(cnt) < READ_STALL));

   a_idle_stall: assert property (@(posedge clk) disable iff (!rst_n)
      ((state == IDLE) && dmem_stall) |-> dmem_ren);
`endif

endmodule

// File: tb/tb_svc_rv_dmem_resp.sv
// Self-checking bench for svc_rv_dmem_resp: three instances (READ_STALL = 0, 2, 3)
// driven by a vector table, directed corner sequences and randomized transactions.
module tb_svc_rv_dmem_resp;

   localparam int NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n [NI];
   logic        ren   [NI];
   logic [31:0] raddr [NI];
   logic [31:0] rdata [NI];
   logic        we    [NI];
   logic [31:0] waddr [NI];
   logic [31:0] wdata [NI];
   logic [3:0]  wstrb [NI];
   logic        stall [NI];

   svc_rv_dmem_resp #(.AW(10), .READ_STALL(0)) u_rs0 (
      .clk(clk), .rst_n(rst_n[0]), .dmem_ren(ren[0]), .dmem_raddr(raddr[0]),
      .dmem_rdata(rdata[0]), .dmem_we(we[0]), .dmem_waddr(waddr[0]),
      .dmem_wdata(wdata[0]), .dmem_wstrb(wstrb[0]), .dmem_stall(stall[0]));

   svc_rv_dmem_resp #(.AW(10), .READ_STALL(2)) u_rs2 (
      .clk(clk), .rst_n(rst_n[1]), .dmem_ren(ren[1]), .dmem_raddr(raddr[1]),
      .dmem_rdata(rdata[1]), .dmem_we(we[1]), .dmem_waddr(waddr[1]),
      .dmem_wdata(wdata[1]), .dmem_wstrb(wstrb[1]), .dmem_stall(stall[1]));

   svc_rv_dmem_resp #(.AW(10), .READ_STALL(3)) u_rs3 (
      .clk(clk), .rst_n(rst_n[2]), .dmem_ren(ren[2]), .dmem_raddr(raddr[2]),
      .dmem_rdata(rdata[2]), .dmem_we(we[2]), .dmem_waddr(waddr[2]),
      .dmem_wdata(wdata[2]), .dmem_wstrb(wstrb[2]), .dmem_stall(stall[2]));

   int vectors     = 0;
   int miscompares = 0;

   // Reference: word array plus last returned read value per instance.
   logic [31:0] mm  [NI][1024];
   logic [31:0] mrd [NI];

   typedef struct {
      bit          r;
      logic [31:0] ra;
      bit          w;
      logic [31:0] wa;
      logic [31:0] wd;
      logic [3:0]  ws;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t tbl [14];

   function automatic int stall_of(input int k);
      case (k)
         0:       return 0;
         1:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic logic [31:0] mk_addr(input int w);
      return ($urandom & 32'hFFFF_F003) | (32'(w) << 2);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One core-side transaction, started just after a rising edge; the request is held
   // for the full stall window plus the capture cycle, then the model is updated.
   task automatic do_txn(input int k, input bit r, input logic [31:0] ra, input bit w,
                         input logic [31:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                         input string tag);
      int n;
      n = r ? stall_of(k) : 0;
      ren[k] = r;  raddr[k] = ra;
      we[k]  = w;  waddr[k] = wa;  wdata[k] = wd;  wstrb[k] = ws;
      for (int c = 0; c <= n; c++) begin
         @(negedge clk);
         check({tag, "_stall"}, 32'(stall[k]), (c < n) ? 32'd1 : 32'd0);
         check({tag, "_rdata_hold"}, rdata[k], mrd[k]);
         @(posedge clk); #1;
      end
      if (r) mrd[k] = mm[k][ra[11:2]];
      if (w) begin
         for (int i = 0; i < 4; i++) begin
            if (ws[i]) mm[k][wa[11:2]][8*i +: 8] = wd[8*i +: 8];
         end
      end
      ren[k] = 1'b0;  we[k] = 1'b0;  wstrb[k] = 4'h0;
   endtask

   task automatic idle_check(input int k, input string name, input logic [31:0] exp);
      @(negedge clk);
      check({name, "_rdata"}, rdata[k], exp);
      check({name, "_stall"}, 32'(stall[k]), 32'd0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      for (int k = 0; k < NI; k++) begin
         rst_n[k] = 1'b0; ren[k] = 1'b0; raddr[k] = '0; we[k] = 1'b0;
         waddr[k] = '0; wdata[k] = '0; wstrb[k] = '0; mrd[k] = '0;
      end

      tbl[0]  = '{1'b0, 32'h0,    1'b1, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0};
      tbl[1]  = '{1'b1, 32'h10,   1'b0, 32'h0,    32'h0,        4'h0, 32'hDEADBEEF};
      tbl[2]  = '{1'b0, 32'h0,    1'b1, 32'h20,   32'h11223344, 4'hF, 32'hDEADBEEF};
      tbl[3]  = '{1'b0, 32'h0,    1'b1, 32'h20,   32'hAABBCCDD, 4'h5, 32'hDEADBEEF};
      tbl[4]  = '{1'b1, 32'h20,   1'b0, 32'h0,    32'h0,        4'h0, 32'h11BB33DD};
      tbl[5]  = '{1'b0, 32'h0,    1'b1, 32'h30,   32'h5,        4'hF, 32'h11BB33DD};
      tbl[6]  = '{1'b1, 32'h30,   1'b1, 32'h30,   32'h9,        4'hF, 32'h5};
      tbl[7]  = '{1'b1, 32'h30,   1'b0, 32'h0,    32'h0,        4'h0, 32'h9};
      tbl[8]  = '{1'b0, 32'h0,    1'b1, 32'h1000, 32'hCAFEF00D, 4'hF, 32'h9};
      tbl[9]  = '{1'b1, 32'h0,    1'b0, 32'h0,    32'h0,        4'h0, 32'hCAFEF00D};
      tbl[10] = '{1'b0, 32'h0,    1'b1, 32'h40,   32'h0,        4'hF, 32'hCAFEF00D};
      tbl[11] = '{1'b0, 32'h0,    1'b1, 32'h40,   32'hFFFFFFFF, 4'h0, 32'hCAFEF00D};
      tbl[12] = '{1'b1, 32'h40,   1'b0, 32'h0,    32'h0,        4'h0, 32'h0};
      tbl[13] = '{1'b1, 32'h1013, 1'b0, 32'h0,    32'h0,        4'h0, 32'hDEADBEEF};

      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) rst_n[k] = 1'b1;
      @(negedge clk);
      for (int k = 0; k < NI; k++) begin
         check($sformatf("reset_rdata_%0d", k), rdata[k], 32'h0);
         check($sformatf("reset_stall_%0d", k), 32'(stall[k]), 32'd0);
      end
      @(posedge clk); #1;

      // Vector table on the zero-stall instance.
      for (int i = 0; i < 14; i++) begin
         do_txn(0, tbl[i].r, tbl[i].ra, tbl[i].w, tbl[i].wa, tbl[i].wd, tbl[i].ws,
                $sformatf("tbl%0d", i));
         idle_check(0, $sformatf("tbl%0d_result", i), tbl[i].exp_rdata);
      end

      // READ_STALL=2: stall window and a write held across a read stall.
      do_txn(1, 1'b0, 32'h0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, "rs2_wr");
      do_txn(1, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, "rs2_rd");
      idle_check(1, "rs2_rd_result", 32'hDEADBEEF);
      do_txn(1, 1'b0, 32'h0, 1'b1, 32'h60, 32'h66, 4'hF, "rs2_pre");
      do_txn(1, 1'b1, 32'h60, 1'b1, 32'h60, 32'h77, 4'hF, "rs2_held");
      idle_check(1, "rs2_held_old", 32'h66);
      do_txn(1, 1'b1, 32'h60, 1'b0, 32'h0, 32'h0, 4'h0, "rs2_after");
      idle_check(1, "rs2_held_new", 32'h77);

      // READ_STALL=3: reset in the second stall cycle aborts the read.
      do_txn(2, 1'b0, 32'h0, 1'b1, 32'h10, 32'hABCD0123, 4'hF, "rs3_w0");
      do_txn(2, 1'b0, 32'h0, 1'b1, 32'h14, 32'h00005555, 4'hF, "rs3_w1");
      do_txn(2, 1'b1, 32'h10, 1'b0, 32'h0, 32'h0, 4'h0, "rs3_rd0");
      idle_check(2, "rs3_rd0_result", 32'hABCD0123);
      ren[2] = 1'b1; raddr[2] = 32'h14;
      @(negedge clk);
      check("rs3_abort_stall_c0", 32'(stall[2]), 32'd1);
      @(posedge clk); #1;
      rst_n[2] = 1'b0; ren[2] = 1'b0;
      @(negedge clk);
      check("rs3_abort_stall_c1", 32'(stall[2]), 32'd1);
      @(posedge clk); #1;
      rst_n[2] = 1'b1;
      mrd[2] = 32'h0;
      idle_check(2, "rs3_after_reset", 32'h0);
      do_txn(2, 1'b1, 32'h14, 1'b0, 32'h0, 32'h0, 4'h0, "rs3_fresh");
      idle_check(2, "rs3_fresh_result", 32'h00005555);

      // Randomized traffic against the reference model on every instance.
      for (int k = 0; k < NI; k++) begin
         for (int w = 0; w < 16; w++) begin
            do_txn(k, 1'b0, 32'h0, 1'b1, mk_addr(w), $urandom, 4'hF, "rnd_fill");
         end
         for (int it = 0; it < 150; it++) begin
            int op;
            op = $urandom_range(0, 3);
            case (op)
               0: do_txn(k, 1'b1, mk_addr($urandom_range(0, 15)), 1'b0, 32'h0, 32'h0, 4'h0,
                         $sformatf("rnd%0d_rd_%0d", k, it));
               1: do_txn(k, 1'b0, 32'h0, 1'b1, mk_addr($urandom_range(0, 15)), $urandom,
                         4'($urandom_range(0, 15)), $sformatf("rnd%0d_wr_%0d", k, it));
               2: do_txn(k, 1'b1, mk_addr($urandom_range(0, 15)), 1'b1,
                         mk_addr($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)),
                         $sformatf("rnd%0d_rw_%0d", k, it));
               default: do_txn(k, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0,
                               $sformatf("rnd%0d_idle_%0d", k, it));
            endcase
         end
         idle_check(k, $sformatf("rnd%0d_final", k), mrd[k]);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
